imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Boot-time writer for the single-cycle core's instruction memory, the producer side of what the fetch/decode path consumes.
- Accepts a little-endian byte stream over a valid/ready handshake and assembles 32-bit instruction words.
- Optionally screens each word's opcode against the set the main decoder supports, then writes the word into instruction memory.
- Holds the core in reset until a complete image with a matching XOR checksum has been loaded.

Parameters:
- ADDR_WIDTH, 8, instruction-memory word-address width; depth = 2**ADDR_WIDTH words.
- CHECK_OPCODES, 1, when 1 a word with an unsupported opcode aborts the load.

Ports:
- clk  input  1  core clock.
- reset  input  1  synchronous, active-high reset; one clock; sampled on rising edge of clk.
- start  input  1  single-cycle pulse that begins a load.
- len_words  input  ADDR_WIDTH+1  number of instruction words in the image, latched on start.
- byte_valid  input  1  byte_data is valid.
- byte_data  input  8  stream byte.
- byte_ready  output  1  loader accepts a byte this cycle.
- imem_we  output  1  instruction-memory write strobe, one cycle per word.
- imem_addr  output  ADDR_WIDTH  word address of the write.
- imem_wdata  output  32  instruction word.
- core_reset  output  1  holds the core in reset while high.
- busy  output  1  high in LOAD or CHECK.
- done  output  1  image loaded and verified.
- err  output  1  load failed.
- err_code  output  2  00 none, 01 bad length, 10 illegal opcode, 11 checksum mismatch.

Behaviour:
- Reset values:
  - imem_we=0, imem_addr=0, imem_wdata=0, byte_ready=0, busy=0, done=0, err=0, err_code=00.
  - core_reset=1.
  - Internal state=IDLE; byte index=0; word count=0; checksum accumulator=0.
- States: IDLE, LOAD, CHECK, DONE, ERROR.
- start in IDLE, DONE or ERROR:
  - Clears done, err, err_code, accumulator, byte index and word address; core_reset=1.
  - If len_words==0 or len_words>2**ADDR_WIDTH: go to ERROR, err_code=01.
  - Otherwise go to LOAD.
- start in LOAD or CHECK is ignored.
- Handshake:
  - byte_ready is registered, high exactly while in LOAD or CHECK.
  - A byte transfers on a cycle with byte_valid & byte_ready.
  - byte_valid without byte_ready is held off; there is no backpressure requirement on the sender beyond this.
- LOAD:
  - Bytes fill the word little-endian: byte 0 goes to bits 7:0, and so on up to byte 3 at bits 31:24.
  - On the cycle the 4th byte transfers, the word is complete.
  - If CHECK_OPCODES=1 and word[6:0] is not in {0000011, 0100011, 0110011, 1100011}: go to ERROR with err_code=10. The word is not written.
  - Otherwise, on the next cycle: imem_we=1 for one cycle, imem_addr=current word index, imem_wdata=word. The word is XORed into the accumulator and the word index is incremented.
  - Write latency: 1 cycle after the 4th-byte transfer.
  - After the len_words-th word completes, go to CHECK. The final imem_we pulse still occurs in the first CHECK cycle.
- CHECK:
  - Receives 4 checksum bytes, little-endian.
  - On the 4th transfer: if the value equals the accumulator, go to DONE; else go to ERROR with err_code=11.
- DONE: done=1 and core_reset=0, held until reset or start.
- ERROR: err=1 and core_reset=1, held until reset or start; byte_ready=0.
- Word index wrap: this is impossible, because len_words is bounded by the depth check; the address never wraps.
- reset mid-load: immediate return to reset values on the next edge. The partial image is left in memory; core_reset=1.
- busy=1 exactly in LOAD and CHECK; done and err are never both 1.

Decomposition:
- Package imem_loader_pkg holds:
  - State enum.
  - Opcode constants OP_LOAD=0000011, OP_STORE=0100011, OP_RTYPE=0110011, OP_BRANCH=1100011. These are shared with the main decoder.
  - err_code constants.
- One sub-module, word_assembler: byte shift-in, 2-bit byte index, and a word_valid pulse. Used by both LOAD and CHECK.

Test Plan:
- Reset: assert reset 2 cycles -> all outputs at reset values, core_reset=1, byte_ready=0.
- Good image:
  - Stimulus: start with len_words=2, then stream 83 20 00 00 B3 81 20 00 and checksum 30 A1 20 00.
  - Required: imem_we pulse at addr 0 with 0x00002083, then at addr 1 with 0x002081B3, each 1 cycle after the 4th byte; then done=1, core_reset=0.
- Stall: deassert byte_valid for 5 cycles mid-word -> no spurious write; the assembled word is still 0x002081B3.
- Illegal opcode:
  - Stimulus: len_words=1, bytes 93 00 50 00 (0x00500093).
  - Required: no imem_we; err=1, err_code=10, byte_ready=0 within 1 cycle.
- Bad checksum: good two-word image with checksum 31 A1 20 00 -> both writes occur; err_code=11, core_reset=1.
- Length and restart cases:
  - start with len_words=0, and separately with 2**ADDR_WIDTH+1 -> err_code=01 and no byte_ready.
  - Then start with len_words=1 and a valid word -> err cleared and load succeeds.
- Reset mid-load: assert reset after 6 bytes -> outputs return to reset values and no further imem_we.

Source files
------------

// File: rtl/imem_loader_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// imem_loader_pkg : states, decoder opcodes and error codes shared by the
//                   instruction-memory loader.
// Revision: 1.0
// ---------------------------------------------------------------------------
package imem_loader_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_CHECK = 3'd2,
      ST_DONE  = 3'd3,
      ST_ERROR = 3'd4
   } state_t;

   // Opcodes also consumed by the main decoder; keep the two in step.
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   localparam logic [1:0] ERR_NONE   = 2'b00;
   localparam logic [1:0] ERR_LEN    = 2'b01;
   localparam logic [1:0] ERR_OPCODE = 2'b10;
   localparam logic [1:0] ERR_CSUM   = 2'b11;

   function automatic logic opcode_supported(input logic [6:0] op);
      return (op == OP_LOAD) || (op == OP_STORE) ||
             (op == OP_RTYPE) || (op == OP_BRANCH);
   endfunction

endpackage
`default_nettype wire

// File: rtl/imem_loader_word_assembler.sv
`default_nettype none
// ---------------------------------------------------------------------------
// word_assembler : packs four little-endian bytes into a 32-bit word and
//                  pulses word_valid_o on the cycle the 4th byte arrives.
// Revision: 1.0
// ---------------------------------------------------------------------------
module word_assembler (
   input  logic        clk,
   input  logic        reset,
   input  logic        clr_i,
   input  logic        take_i,
   input  logic [7:0]  byte_i,
   output logic [31:0] word_o,
   output logic        word_valid_o
);

   logic [1:0]  idx_q, idx_d;
   logic [23:0] low_q, low_d;

   always_comb begin
      idx_d = idx_q;
      low_d = low_q;
      if (clr_i) begin
         idx_d = 2'd0;
         low_d = 24'd0;
      end else if (take_i) begin
         case (idx_q)
            2'd0:    low_d[7:0]   = byte_i;
            2'd1:    low_d[15:8]  = byte_i;
            2'd2:    low_d[23:16] = byte_i;
            default: low_d        = low_q;
         endcase
         idx_d = idx_q + 2'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         idx_q <= 2'd0;
         low_q <= 24'd0;
      end else begin
         idx_q <= idx_d;
         low_q <= low_d;
      end
   end

   // The top byte is taken straight from the bus so the word is usable
   // in the same cycle as its last transfer.
   assign word_o       = {byte_i, low_q};
   assign word_valid_o = take_i & ~clr_i & (idx_q == 2'd3);

endmodule
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ---------------------------------------------------------------------------
// imem_loader : boot-time byte-stream writer for instruction memory; holds
//               the core in reset until a checksummed image is loaded.
// Revision: 1.0
// ---------------------------------------------------------------------------
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int ADDR_WIDTH    = 8,
   parameter bit CHECK_OPCODES = 1'b1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [ADDR_WIDTH:0]   len_words,
   input  logic                  byte_valid,
   input  logic [7:0]            byte_data,
   output logic                  byte_ready,
   output logic                  imem_we,
   output logic [ADDR_WIDTH-1:0] imem_addr,
   output logic [31:0]           imem_wdata,
   output logic                  core_reset,
   output logic                  busy,
   output logic                  done,
   output logic                  err,
   output logic [1:0]            err_code
);

   localparam logic [ADDR_WIDTH:0] DEPTH   = {1'b1, {ADDR_WIDTH{1'b0}}};
   localparam logic [ADDR_WIDTH:0] CNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

   state_t                state_q, state_d;
   logic [ADDR_WIDTH:0]   len_q, len_d;
   logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
   logic [31:0]           acc_q, acc_d;
   logic                  we_q, we_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [31:0]           wdata_q, wdata_d;
   logic                  ready_q, ready_d;
   logic [1:0]            code_q, code_d;

   logic                  take;
   logic                  asm_clr;
   logic [31:0]           word;
   logic                  word_valid;
   logic                  op_ok;
   logic [ADDR_WIDTH:0]   cnt_inc;

   assign take    = byte_valid & ready_q;
   assign cnt_inc = cnt_q + CNT_ONE;

   word_assembler u_asm (
      .clk          (clk),
      .reset        (reset),
      .clr_i        (asm_clr),
      .take_i       (take),
      .byte_i       (byte_data),
      .word_o       (word),
      .word_valid_o (word_valid)
   );

   generate
      if (CHECK_OPCODES) begin : g_opchk
         assign op_ok = opcode_supported(word[6:0]);
      end else begin : g_noopchk
         assign op_ok = 1'b1;
      end
   endgenerate

   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      we_d    = 1'b0;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      code_d  = code_q;
      asm_clr = 1'b0;
      case (state_q)
         ST_LOAD: begin
            if (word_valid) begin
               if (!op_ok) begin
                  state_d = ST_ERROR;
                  code_d  = ERR_OPCODE;
               end else begin
                  we_d    = 1'b1;
                  addr_d  = cnt_q[ADDR_WIDTH-1:0];
                  wdata_d = word;
                  acc_d   = acc_q ^ word;
                  cnt_d   = cnt_inc;
                  if (cnt_inc == len_q) state_d = ST_CHECK;
               end
            end
         end
         ST_CHECK: begin
            if (word_valid) begin
               if (word == acc_q) begin
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_ERROR;
                  code_d  = ERR_CSUM;
               end
            end
         end
         default: begin
            if (start) begin
               asm_clr = 1'b1;
               len_d   = len_words;
               cnt_d   = '0;
               acc_d   = 32'd0;
               addr_d  = '0;
               code_d  = ERR_NONE;
               if ((len_words == '0) || (len_words > DEPTH)) begin
                  state_d = ST_ERROR;
                  code_d  = ERR_LEN;
               end else begin
                  state_d = ST_LOAD;
               end
            end
         end
      endcase
      ready_d = (state_d == ST_LOAD) || (state_d == ST_CHECK);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         len_q   <= '0;
         cnt_q   <= '0;
         acc_q   <= 32'd0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= 32'd0;
         ready_q <= 1'b0;
         code_q  <= ERR_NONE;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         ready_q <= ready_d;
         code_q  <= code_d;
      end
   end

   assign byte_ready = ready_q;
   assign imem_we    = we_q;
   assign imem_addr  = addr_q;
   assign imem_wdata = wdata_q;
   assign busy       = (state_q == ST_LOAD) || (state_q == ST_CHECK);
   assign done       = (state_q == ST_DONE);
   assign err        = (state_q == ST_ERROR);
   assign core_reset = (state_q != ST_DONE);
   assign err_code   = code_q;

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_imem_loader : randomized and directed bench for imem_loader with a
//                  queue-based behavioural model and per-cycle comparison.
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_imem_loader;

   localparam int AW    = 8;
   localparam int DEPTH = 1 << AW;

   localparam int M_IDLE  = 0;
   localparam int M_LOAD  = 1;
   localparam int M_CHECK = 2;
   localparam int M_DONE  = 3;
   localparam int M_ERR   = 4;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          start = 1'b0;
   logic [AW:0]   len_words = '0;
   logic          byte_valid = 1'b0;
   logic [7:0]    byte_data = 8'd0;
   logic          byte_ready;
   logic          imem_we;
   logic [AW-1:0] imem_addr;
   logic [31:0]   imem_wdata;
   logic          core_reset;
   logic          busy;
   logic          done;
   logic          err;
   logic [1:0]    err_code;

   int total = 0;
   int bad   = 0;
   bit chk_en = 1'b0;

   imem_loader #(.ADDR_WIDTH(AW), .CHECK_OPCODES(1'b1)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .len_words  (len_words),
      .byte_valid (byte_valid),
      .byte_data  (byte_data),
      .byte_ready (byte_ready),
      .imem_we    (imem_we),
      .imem_addr  (imem_addr),
      .imem_wdata (imem_wdata),
      .core_reset (core_reset),
      .busy       (busy),
      .done       (done),
      .err        (err),
      .err_code   (err_code)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   int          m_st = M_IDLE;
   logic [7:0]  m_bytes[$];
   int          m_len = 0;
   int          m_cnt = 0;
   logic [31:0] m_acc = 32'd0;
   bit          m_we = 1'b0;
   int          m_addr = 0;
   logic [31:0] m_wdata = 32'd0;
   logic [1:0]  m_code = 2'b00;

   function automatic bit model_legal(input logic [6:0] op);
      return op == 7'h03 || op == 7'h23 || op == 7'h33 || op == 7'h63;
   endfunction

   always @(posedge clk) begin
      logic [31:0] w;
      m_we = 1'b0;
      if (reset) begin
         m_st = M_IDLE; m_bytes.delete(); m_cnt = 0; m_acc = 0; m_code = 2'b00;
      end else if (start && m_st != M_LOAD && m_st != M_CHECK) begin
         m_bytes.delete(); m_cnt = 0; m_acc = 0; m_code = 2'b00;
         m_len = int'(len_words);
         if (m_len == 0 || m_len > DEPTH) begin
            m_st = M_ERR; m_code = 2'b01;
         end else begin
            m_st = M_LOAD;
         end
      end else if (byte_valid && (m_st == M_LOAD || m_st == M_CHECK)) begin
         m_bytes.push_back(byte_data);
         if (m_bytes.size() == 4) begin
            w = {m_bytes[3], m_bytes[2], m_bytes[1], m_bytes[0]};
            m_bytes.delete();
            if (m_st == M_LOAD) begin
               if (!model_legal(w[6:0])) begin
                  m_st = M_ERR; m_code = 2'b10;
               end else begin
                  m_we = 1'b1; m_addr = m_cnt; m_wdata = w;
                  m_acc = m_acc ^ w; m_cnt++;
                  if (m_cnt == m_len) m_st = M_CHECK;
               end
            end else if (w == m_acc) begin
               m_st = M_DONE;
            end else begin
               m_st = M_ERR; m_code = 2'b11;
            end
         end
      end
   end

   // ---------------- per-cycle comparison ----------------
   logic [AW-1:0] log_addr[$];
   logic [31:0]   log_data[$];

   always @(negedge clk) begin
      bit r;
      if (chk_en) begin
         r = (m_st == M_LOAD) || (m_st == M_CHECK);
         check("status", {56'd0, byte_ready, busy, done, err, core_reset, err_code, imem_we},
               {56'd0, r, r, m_st == M_DONE, m_st == M_ERR, m_st != M_DONE, m_code, m_we});
         if (m_we) check("write", {24'd0, imem_addr, imem_wdata}, {24'd0, m_addr[AW-1:0], m_wdata});
      end
      if (imem_we) begin
         log_addr.push_back(imem_addr);
         log_data.push_back(imem_wdata);
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic do_start(input int len);
      @(negedge clk);
      start = 1'b1; len_words = len[AW:0]; byte_valid = 1'b0;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap, input bit rnd_start);
      int n;
      for (int i = 0; i < gap; i++) begin
         @(negedge clk);
         byte_valid = 1'b0; byte_data = 8'($urandom);
         start = rnd_start && ($urandom_range(0, 5) == 0);
         len_words = (AW+1)'($urandom);
      end
      @(negedge clk);
      start = 1'b0; byte_valid = 1'b1; byte_data = b;
      n = 0;
      while (!byte_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) begin
         total++; bad++;
         $display("FAIL handshake_timeout actual byte_ready=%b required=1", byte_ready);
         byte_valid = 1'b0;
      end
   endtask

   task automatic send_word(input logic [31:0] w, input int gmax, input bit rnd_start);
      for (int k = 0; k < 4; k++)
         send_byte(w[8*k +: 8], (gmax == 0) ? 0 : $urandom_range(0, gmax), rnd_start);
   endtask

   task automatic end_bytes();
      @(negedge clk);
      byte_valid = 1'b0; start = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   function automatic logic [31:0] rand_word(input bit legal);
      logic [31:0] r;
      logic [6:0]  op;
      r = $urandom;
      if (legal) begin
         case ($urandom_range(0, 3))
            0:       op = 7'h03;
            1:       op = 7'h23;
            2:       op = 7'h33;
            default: op = 7'h63;
         endcase
      end else begin
         case ($urandom_range(0, 3))
            0:       op = 7'h13;
            1:       op = 7'h37;
            2:       op = 7'h6F;
            default: op = 7'h00;
         endcase
      end
      return {r[31:7], op};
   endfunction

   localparam logic [47:0] RST_VEC = {1'b0, 8'h00, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1};

   initial begin
      int          n0;
      logic [31:0] acc, w;
      int          len, bad_at, gm;
      bit          csum_ok, aborted;

      // Reset held two cycles
      reset = 1'b1;
      repeat (2) @(negedge clk);
      chk_en = 1'b1;
      check("reset_values", {16'd0, imem_we, imem_addr, imem_wdata, byte_ready, busy, done, err, err_code, core_reset},
            {16'd0, RST_VEC});
      reset = 1'b0;
      idle(2);

      // Good image, stall of 5 cycles inside the second word
      n0 = log_addr.size();
      do_start(2);
      send_word(32'h0000_2083, 0, 0);
      send_byte(8'hB3, 0, 0); send_byte(8'h81, 0, 0);
      send_byte(8'h20, 5, 0); send_byte(8'h00, 0, 0);
      send_word(32'h0020_A130, 0, 0);
      end_bytes();
      idle(2);
      check("good_nwrites", 64'(log_addr.size() - n0), 64'd2);
      if (log_addr.size() >= n0 + 2) begin
         check("good_w0", {log_addr[n0], log_data[n0]}, {8'd0, 32'h0000_2083});
         check("good_w1", {log_addr[n0+1], log_data[n0+1]}, {8'd1, 32'h0020_81B3});
      end
      check("good_done", {done, err, core_reset}, 3'b100);

      // Illegal opcode
      n0 = log_addr.size();
      do_start(1);
      send_word(32'h0050_0093, 0, 0);
      end_bytes();
      check("illegal_flags", {err, err_code, byte_ready}, {1'b1, 2'b10, 1'b0});
      idle(2);
      check("illegal_nowrite", 64'(log_addr.size() - n0), 64'd0);

      // Bad checksum
      n0 = log_addr.size();
      do_start(2);
      send_word(32'h0000_2083, 0, 0);
      send_word(32'h0020_81B3, 0, 0);
      send_word(32'h0020_A131, 0, 0);
      end_bytes();
      idle(2);
      check("csum_nwrites", 64'(log_addr.size() - n0), 64'd2);
      check("csum_flags", {err, err_code, core_reset, done}, {1'b1, 2'b11, 1'b1, 1'b0});

      // Length boundaries, then recovery
      do_start(0);
      idle(1);
      check("len0", {err, err_code, byte_ready}, {1'b1, 2'b01, 1'b0});
      do_start(DEPTH + 1);
      idle(1);
      check("len_over", {err, err_code, byte_ready}, {1'b1, 2'b01, 1'b0});
      do_start(1);
      send_word(32'h00A5_0033, 0, 0);
      send_word(32'h00A5_0033, 0, 0);
      end_bytes();
      idle(1);
      check("recover", {done, err, err_code, core_reset}, {1'b1, 1'b0, 2'b00, 1'b0});

      // Reset after six bytes
      n0 = log_addr.size();
      do_start(2);
      send_word(32'h0000_2083, 0, 0);
      send_byte(8'hB3, 0, 0); send_byte(8'h81, 0, 0);
      @(negedge clk);
      byte_valid = 1'b0; reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("midrst_values", {16'd0, imem_we, imem_addr, imem_wdata, byte_ready, busy, done, err, err_code, core_reset},
            {16'd0, RST_VEC});
      idle(10);
      check("midrst_nwrites", 64'(log_addr.size() - n0), 64'd1);

      // Full-depth image
      n0 = log_addr.size();
      acc = 32'd0;
      do_start(DEPTH);
      for (int i = 0; i < DEPTH; i++) begin
         w = rand_word(1'b1);
         acc ^= w;
         send_word(w, 0, 0);
      end
      send_word(acc, 0, 0);
      end_bytes();
      idle(1);
      check("full_nwrites", 64'(log_addr.size() - n0), 64'(DEPTH));
      check("full_done", {done, err}, 2'b10);

      // Randomized images with gaps, stray starts, bad opcodes and checksums
      for (int it = 0; it < 40; it++) begin
         len     = $urandom_range(1, 8);
         bad_at  = ($urandom_range(0, 7) == 0) ? $urandom_range(0, len - 1) : -1;
         csum_ok = ($urandom_range(0, 3) != 0);
         gm      = $urandom_range(0, 3);
         aborted = 1'b0;
         acc     = 32'd0;
         do_start(len);
         for (int i = 0; i < len; i++) begin
            w = rand_word(i != bad_at);
            send_word(w, gm, 1'b1);
            acc ^= w;
            if (i == bad_at) begin
               aborted = 1'b1;
               break;
            end
         end
         if (!aborted)
            send_word(csum_ok ? acc : acc ^ (32'h1 << $urandom_range(0, 31)), gm, 1'b1);
         // Bytes offered while the loader is not accepting
         repeat (3) begin
            @(negedge clk);
            byte_valid = 1'b1; byte_data = 8'($urandom);
         end
         end_bytes();
         idle(1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
